hangman_guess_ctrl: RTL and testbench

- Sequences one hangman guess against the stored secret word.
- Accepts a guess letter via valid/ready handshake and rejects invalid or repeated letters.
- Scans the word memory letter by letter, updates the reveal mask and miss counter, and reports hit/miss plus win/lose.
- Sits between keyboard decode and the drawing/fill logic, replacing ad-hoc match/fill/draw sequencing in the top game FSM.

---
 rtl/hangman_guess_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hangman_guess_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hangman_guess_ctrl.sv
// Hangman guess sequencer: accepts one letter, rejects repeats/invalid codes,
// scans the word memory, updates the reveal mask and miss counter, reports win/lose.
module hangman_guess_ctrl #(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned MAX_MISS = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              new_game,
    input  logic [AW:0]       word_len,
    input  logic              guess_valid,
    input  logic [4:0]        guess_char,
    output logic              guess_ready,
    output logic [AW-1:0]     mem_addr,
    input  logic [4:0]        mem_rdata,
    output logic [MAX_LEN-1:0] reveal,
    output logic [2:0]        misses,
    output logic              busy,
    output logic              result_valid,
    output logic              hit,
    output logic              dup,
    output logic              win,
    output logic              lose
);

    localparam int unsigned LW    = AW + 1;
    localparam int unsigned N_LET = 26;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_READ   = 3'd2,
        S_CMP    = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

    state_t               r_state;
    logic [LW-1:0]        r_len;
    logic [4:0]           r_guess;
    logic [N_LET-1:0]     r_used;
    logic                 r_match;
    logic                 r_dup_pend;
    logic [MAX_LEN-1:0]   r_reveal;
    logic [2:0]           r_misses;
    logic [AW-1:0]        r_mem_addr;
    logic                 r_busy;
    logic                 r_result_valid;
    logic                 r_hit;
    logic                 r_dup;
    logic                 r_win;
    logic                 r_lose;

    logic [LW-1:0]        w_len_clamped;
    logic [MAX_LEN-1:0]   w_len_mask;
    logic                 w_all_revealed;
    logic [31:0]          w_used_ext;
    logic                 w_is_dup;
    logic                 w_last;
    logic                 w_ready;

    // Length clamp applied when a new game latches word_len
    always_comb begin
        w_len_clamped = word_len;
        if (word_len == LW'(0)) begin
            w_len_clamped = LW'(1);
        end else if (word_len > LW'(MAX_LEN)) begin
            w_len_clamped = LW'(MAX_LEN);
        end
    end

    always_comb begin
        w_len_mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            w_len_mask[i] = (LW'(i) < r_len);
        end
    end

    assign w_all_revealed = &(r_reveal | ~w_len_mask);
    assign w_used_ext     = {6'd0, r_used};
    assign w_is_dup       = (r_guess > 5'd25) || w_used_ext[r_guess];
    assign w_last         = (r_mem_addr == AW'(r_len - LW'(1)));
    // Ready is withheld during the result pulse so a finishing guess can end the game first
    assign w_ready        = (r_state == S_IDLE) && !r_win && !r_lose && !r_result_valid;

    always_ff @(posedge clk) begin
        if (resetn || new_game) begin
            r_state        <= S_IDLE;
            r_len          <= resetn ? LW'(1) : w_len_clamped;
            r_guess        <= '0;
            r_used         <= '0;
            r_match        <= 1'b0;
            r_dup_pend     <= 1'b0;
            r_reveal       <= '0;
            r_misses       <= '0;
            r_mem_addr     <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_hit          <= 1'b0;
            r_dup          <= 1'b0;
            r_win          <= 1'b0;
            r_lose         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            // Game-end levels follow the result pulse by one cycle
            if (r_result_valid) begin
                r_win  <= r_win | w_all_revealed;
                r_lose <= r_lose | (r_misses == 3'(MAX_MISS));
            end
            case (r_state)
                S_IDLE: begin
                    if (guess_valid && w_ready) begin
                        r_guess <= guess_char;
                        r_busy  <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_is_dup) begin
                        r_dup_pend <= 1'b1;
                        r_state    <= S_UPDATE;
                    end else begin
                        r_used[r_guess] <= 1'b1;
                        r_mem_addr      <= '0;
                        r_match         <= 1'b0;
                        r_dup_pend      <= 1'b0;
                        r_state         <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    if (mem_rdata == r_guess) begin
                        r_reveal[r_mem_addr] <= 1'b1;
                        r_match              <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= S_UPDATE;
                    end else begin
                        r_mem_addr <= r_mem_addr + AW'(1);
                        r_state    <= S_READ;
                    end
                end
                S_UPDATE: begin
                    r_result_valid <= 1'b1;
                    r_busy         <= 1'b0;
                    r_dup_pend     <= 1'b0;
                    r_state        <= S_IDLE;
                    if (r_dup_pend) begin
                        r_dup <= 1'b1;
                        r_hit <= 1'b0;
                    end else begin
                        r_dup <= 1'b0;
                        r_hit <= r_match;
                        if (!r_match && (r_misses < 3'(MAX_MISS))) begin
                            r_misses <= r_misses + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign guess_ready  = w_ready;
    assign mem_addr     = r_mem_addr;
    assign reveal       = r_reveal;
    assign misses       = r_misses;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign hit          = r_hit;
    assign dup          = r_dup;
    assign win          = r_win;
    assign lose         = r_lose;

endmodule

// File: tb/tb_hangman_guess_ctrl.sv
// Directed bench for hangman_guess_ctrl: behavioural game model feeds a result scoreboard.
module tb_hangman_guess_ctrl;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned AW      = 4;

    logic               clk = 1'b0;
    logic               resetn;
    logic               new_game;
    logic [AW:0]        word_len;
    logic               guess_valid;
    logic [4:0]         guess_char;
    logic               guess_ready;
    logic [AW-1:0]      mem_addr;
    logic [4:0]         mem_rdata;
    logic [MAX_LEN-1:0] reveal;
    logic [2:0]         misses;
    logic               busy;
    logic               result_valid;
    logic               hit;
    logic               dup;
    logic               win;
    logic               lose;

    hangman_guess_ctrl #(.MAX_LEN(MAX_LEN), .AW(AW), .MAX_MISS(6)) dut (
        .clk(clk), .resetn(resetn), .new_game(new_game), .word_len(word_len),
        .guess_valid(guess_valid), .guess_char(guess_char), .guess_ready(guess_ready),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .reveal(reveal), .misses(misses),
        .busy(busy), .result_valid(result_valid), .hit(hit), .dup(dup),
        .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    // Registered word memory, one cycle read latency
    logic [4:0] word_mem [MAX_LEN];
    always @(posedge clk) mem_rdata <= word_mem[mem_addr];

    typedef struct {
        logic        hit;
        logic        dup;
        int          lat;
        logic [15:0] reveal;
        logic [2:0]  misses;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    int          m_len;
    logic [25:0] m_used;
    logic [15:0] m_reveal;
    int          m_misses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic m_win();
        logic w = 1'b1;
        for (int i = 0; i < m_len; i++) if (!m_reveal[i]) w = 1'b0;
        return w;
    endfunction

    task automatic start_game(input int wl);
        word_len = 5'(wl);
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        m_len    = (wl == 0) ? 1 : ((wl > 16) ? 16 : wl);
        m_used   = '0;
        m_reveal = '0;
        m_misses = 0;
    endtask

    task automatic accept_guess(input logic [4:0] c, output logic ok);
        int n = 0;
        ok = 1'b0;
        guess_valid = 1'b1;
        guess_char  = c;
        while (!guess_ready && n < 20) begin
            step();
            n++;
        end
        if (guess_ready) begin
            step();
            ok = 1'b1;
        end
        guess_valid = 1'b0;
    endtask

    // Model predicts the result, pushes it, then pops and compares at the pulse
    task automatic do_guess(input string tag, input logic [4:0] c);
        exp_t e;
        exp_t g;
        logic ok;
        int   cnt;
        e.dup = (c > 5'd25) || m_used[c];
        e.hit = 1'b0;
        if (!e.dup) begin
            m_used[c] = 1'b1;
            for (int i = 0; i < m_len; i++) begin
                if (word_mem[i] == c) begin
                    e.hit       = 1'b1;
                    m_reveal[i] = 1'b1;
                end
            end
            if (!e.hit && m_misses < 6) m_misses++;
        end
        e.lat    = e.dup ? 2 : 2 * m_len + 2;
        e.reveal = m_reveal;
        e.misses = 3'(m_misses);
        sb.push_back(e);

        accept_guess(c, ok);
        check({tag, "_accepted"}, 32'(ok), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cnt = 0;
        while (!result_valid && cnt < 200) begin
            step();
            cnt++;
        end
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            g = sb.pop_front();
            check({tag, "_result_valid"}, 32'(result_valid), 32'd1);
            check({tag, "_latency"}, 32'(cnt), 32'(g.lat));
            check({tag, "_hit"}, 32'(hit), 32'(g.hit));
            check({tag, "_dup"}, 32'(dup), 32'(g.dup));
            check({tag, "_reveal"}, 32'(reveal), 32'(g.reveal));
            check({tag, "_misses"}, 32'(misses), 32'(g.misses));
            check({tag, "_busy_done"}, 32'(busy), 32'd0);
            check({tag, "_win_pre"}, 32'(win), 32'd0);
            check({tag, "_lose_pre"}, 32'(lose), 32'd0);
        end
        step();
        check({tag, "_pulse_len"}, 32'(result_valid), 32'd0);
        check({tag, "_win"}, 32'(win), 32'(m_win()));
        check({tag, "_lose"}, 32'(lose), 32'(m_misses == 6));
    endtask

    task automatic check_blocked(input string tag);
        logic seen = 1'b0;
        guess_valid = 1'b1;
        guess_char  = 5'd1;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | busy | result_valid;
        end
        guess_valid = 1'b0;
        check({tag, "_ready_low"}, 32'(guess_ready), 32'd0);
        check({tag, "_not_accepted"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic ok;
        logic seen;
        resetn      = 1'b1;
        new_game    = 1'b0;
        word_len    = '0;
        guess_valid = 1'b0;
        guess_char  = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) word_mem[i] = 5'd31;
        step();
        step();
        resetn = 1'b0;
        check("rst_reveal", 32'(reveal), 32'd0);
        check("rst_misses", 32'(misses), 32'd0);
        check("rst_ctrl", 32'({mem_addr, busy, result_valid, hit, dup, win, lose}), 32'd0);
        check("rst_ready", 32'(guess_ready), 32'd1);

        // APPLE: A P P L E
        word_mem[0] = 5'd0;  word_mem[1] = 5'd15; word_mem[2] = 5'd15;
        word_mem[3] = 5'd11; word_mem[4] = 5'd4;
        start_game(5);
        do_guess("p_hit", 5'd15);
        check("p_reveal_const", 32'(reveal), 32'h0006);
        do_guess("p_dup", 5'd15);
        do_guess("code27", 5'd27);
        do_guess("miss_z", 5'd25);
        do_guess("miss_q", 5'd16);
        do_guess("miss_x", 5'd23);
        do_guess("miss_j", 5'd9);
        do_guess("miss_k", 5'd10);
        do_guess("miss_v", 5'd21);
        check("lose_const", 32'({lose, misses}), 32'({1'b1, 3'd6}));
        check_blocked("after_lose");

        start_game(5);
        check("ng_clear", 32'({lose, misses, reveal}), 32'd0);
        do_guess("win_a", 5'd0);
        do_guess("win_p", 5'd15);
        do_guess("win_l", 5'd11);
        do_guess("win_e", 5'd4);
        check("win_const", 32'({win, lose, misses, reveal}), 32'({1'b1, 1'b0, 3'd0, 16'h001F}));
        check_blocked("after_win");

        // CAT, with an A beyond the length that must stay hidden
        word_mem[0] = 5'd2; word_mem[1] = 5'd0; word_mem[2] = 5'd19; word_mem[3] = 5'd0;
        start_game(3);
        accept_guess(5'd0, ok);
        check("abort_accepted", 32'(ok), 32'd1);
        step(); step(); step();
        start_game(3);
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            seen = seen | result_valid;
            step();
        end
        check("abort_no_result", 32'(seen), 32'd0);
        check("abort_state", 32'({busy, misses, reveal}), 32'd0);
        do_guess("abort_reguess", 5'd0);
        check("cat_reveal_const", 32'(reveal), 32'h0002);

        word_mem[0] = 5'd7;
        start_game(0);
        do_guess("len0", 5'd7);
        check("len0_win", 32'(win), 32'd1);

        for (int i = 0; i < int'(MAX_LEN); i++) word_mem[i] = 5'(i);
        word_mem[15] = 5'd0;
        start_game(20);
        do_guess("len20_a", 5'd0);
        check("len20_reveal_const", 32'(reveal), 32'h8001);
        do_guess("len20_miss", 5'd24);

        accept_guess(5'd1, ok);
        check("rstmid_accepted", 32'(ok), 32'd1);
        repeat (5) step();
        resetn = 1'b1;
        step();
        check("rstmid_outputs",
              32'({reveal, misses, mem_addr, busy, result_valid, hit, dup, win, lose}), 32'd0);
        resetn = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | result_valid | busy;
            step();
        end
        check("rstmid_no_result", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
